// File: rtl/neo_lb_mixer.sv
// Dual-bank sprite line buffer with clear-after-read and fix-layer mixer.
// One bank is written by the sprite engine while the other is displayed.
module neo_lb_mixer #(
  parameter int ADDR_W   = 9,
  parameter int PAL_W    = 8,
  parameter int FIXPAL_W = 4,
  parameter int COLOR_W  = 4
) (
  input  logic                     CLK_6MB,
  input  logic                     RESET,
  input  logic                     LINE_SWAP,
  input  logic                     LOAD_X,
  input  logic [ADDR_W-1:0]        X_IN,
  input  logic [PAL_W-1:0]         SPR_PAL,
  input  logic                     HFLIP,
  input  logic                     PIX_VALID,
  input  logic [COLOR_W-1:0]       SPR_COLOR,
  input  logic                     RD_EN,
  input  logic [COLOR_W-1:0]       FIX_COLOR,
  input  logic [FIXPAL_W-1:0]      FIX_PAL,
  input  logic                     CHBL,
  output logic [PAL_W+COLOR_W-1:0] PA,
  output logic                     WR_BANK
);

  localparam int ENT_W = PAL_W + COLOR_W;
  localparam int DEPTH = 1 << ADDR_W;

  logic [ENT_W-1:0]  mem_a_q [DEPTH];
  logic [ENT_W-1:0]  mem_b_q [DEPTH];

  logic              wr_bank_q, wr_bank_d;
  logic              seen_q, seen_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic [PAL_W-1:0]  pal_q, pal_d;
  logic              hflip_q, hflip_d;
  logic [ENT_W-1:0]  pa_q, pa_d;

  logic [ADDR_W-1:0] wx;
  logic [PAL_W-1:0]  wpal;
  logic              whf;
  logic              wr_en;
  logic [ENT_W-1:0]  wdata;
  logic [ENT_W-1:0]  rd_entry;
  logic [ENT_W-1:0]  mix;

  always_comb begin
    wx        = LOAD_X ? X_IN : wcnt_q;
    wpal      = LOAD_X ? SPR_PAL : pal_q;
    whf       = LOAD_X ? HFLIP : hflip_q;
    wr_en     = PIX_VALID && (SPR_COLOR != '0);
    wdata     = {wpal, SPR_COLOR};
    pal_d     = wpal;
    hflip_d   = whf;
    wcnt_d    = wcnt_q;
    if (PIX_VALID)
      wcnt_d = whf ? wx - ADDR_W'(1) : wx + ADDR_W'(1);
    else if (LOAD_X)
      wcnt_d = X_IN;

    rd_entry  = wr_bank_q ? mem_a_q[rcnt_q] : mem_b_q[rcnt_q];
    mix       = (FIX_COLOR != '0) ? {PAL_W'(FIX_PAL), FIX_COLOR}
                                  : rd_entry;
    pa_d      = pa_q;
    if (CHBL)
      pa_d = '0;
    else if (RD_EN)
      pa_d = valid_q ? mix : '0;

    rcnt_d    = rcnt_q;
    if (LINE_SWAP)
      rcnt_d = '0;
    else if (RD_EN)
      rcnt_d = rcnt_q + ADDR_W'(1);

    wr_bank_d = wr_bank_q ^ LINE_SWAP;
    seen_d    = seen_q | LINE_SWAP;
    // Second swap after reset: a bank has now been fully cleared by reading
    valid_d   = valid_q | (LINE_SWAP & seen_q);
  end

  always_ff @(posedge CLK_6MB or posedge RESET) begin
    if (RESET) begin
      wr_bank_q <= 1'b0;
      seen_q    <= 1'b0;
      valid_q   <= 1'b0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      pal_q     <= '0;
      hflip_q   <= 1'b0;
      pa_q      <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      seen_q    <= seen_d;
      valid_q   <= valid_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      pal_q     <= pal_d;
      hflip_q   <= hflip_d;
      pa_q      <= pa_d;
    end
  end

  always_ff @(posedge CLK_6MB) begin
    if (!RESET) begin
      if (wr_en && !wr_bank_q)
        mem_a_q[wx] <= wdata;
      if (RD_EN && wr_bank_q)
        mem_a_q[rcnt_q] <= '0;
    end
  end

  always_ff @(posedge CLK_6MB) begin
    if (!RESET) begin
      if (wr_en && wr_bank_q)
        mem_b_q[wx] <= wdata;
      if (RD_EN && !wr_bank_q)
        mem_b_q[rcnt_q] <= '0;
    end
  end

  assign PA      = pa_q;
  assign WR_BANK = wr_bank_q;

endmodule

// File: tb/tb_neo_lb_mixer.sv
// Testbench for neo_lb_mixer: directed scenarios plus random traffic
// checked against a per-pixel line-buffer model.
module tb_neo_lb_mixer;

  logic        clk;
  logic        RESET;
  logic        LINE_SWAP;
  logic        LOAD_X;
  logic [8:0]  X_IN;
  logic [7:0]  SPR_PAL;
  logic        HFLIP;
  logic        PIX_VALID;
  logic [3:0]  SPR_COLOR;
  logic        RD_EN;
  logic [3:0]  FIX_COLOR;
  logic [3:0]  FIX_PAL;
  logic        CHBL;
  logic [11:0] PA;
  logic        WR_BANK;

  neo_lb_mixer dut (
    .CLK_6MB  (clk),
    .RESET    (RESET),
    .LINE_SWAP(LINE_SWAP),
    .LOAD_X   (LOAD_X),
    .X_IN     (X_IN),
    .SPR_PAL  (SPR_PAL),
    .HFLIP    (HFLIP),
    .PIX_VALID(PIX_VALID),
    .SPR_COLOR(SPR_COLOR),
    .RD_EN    (RD_EN),
    .FIX_COLOR(FIX_COLOR),
    .FIX_PAL  (FIX_PAL),
    .CHBL     (CHBL),
    .PA       (PA),
    .WR_BANK  (WR_BANK)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit ls; bit lx; int x; int sp; bit hf;
    bit pv; int col; bit rd; int fc; int fp; bit chbl;
  } in_t;

  int nchk = 0;
  int nerr = 0;

  // reference model: pixel arrays per bank, plain integer state
  int mb [2][512];
  int wb, wc, rc, pal, hf, exp_pa;
  bit valid, seen;

  function automatic in_t idle();
    in_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic model_reset();
    wb = 0; wc = 0; rc = 0; pal = 0; hf = 0;
    valid = 0; seen = 0; exp_pa = 0;
  endtask

  task automatic drive_idle();
    LINE_SWAP = 0; LOAD_X = 0; X_IN = '0; SPR_PAL = '0;
    HFLIP = 0; PIX_VALID = 0; SPR_COLOR = '0; RD_EN = 0;
    FIX_COLOR = '0; FIX_PAL = '0; CHBL = 0;
  endtask

  task automatic cyc(input in_t s);
    int ex, ep, eh, mix, rb;
    LINE_SWAP = s.ls; LOAD_X = s.lx; X_IN = 9'(s.x);
    SPR_PAL = 8'(s.sp); HFLIP = s.hf; PIX_VALID = s.pv;
    SPR_COLOR = 4'(s.col); RD_EN = s.rd; FIX_COLOR = 4'(s.fc);
    FIX_PAL = 4'(s.fp); CHBL = s.chbl;
    ex = s.lx ? s.x : wc;
    ep = s.lx ? s.sp : pal;
    eh = s.lx ? int'(s.hf) : hf;
    if (s.pv && s.col != 0) mb[wb][ex] = ep * 16 + s.col;
    if (s.pv) wc = (eh != 0) ? (ex + 511) % 512 : (ex + 1) % 512;
    else if (s.lx) wc = s.x;
    if (s.lx) begin pal = s.sp; hf = s.hf; end
    rb = 1 - wb;
    mix = (s.fc != 0) ? s.fp * 16 + s.fc : mb[rb][rc];
    if (s.chbl) exp_pa = 0;
    else if (s.rd) exp_pa = valid ? mix : 0;
    if (s.rd) begin mb[rb][rc] = 0; rc = (rc + 1) % 512; end
    if (s.ls) begin
      wb = 1 - wb; rc = 0;
      if (seen) valid = 1;
      seen = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_sprite(input int x, input int p, input bit h,
                              input int cols[$]);
    in_t s;
    s = idle(); s.lx = 1; s.x = x; s.sp = p; s.hf = h;
    cyc(s);
    foreach (cols[i]) begin
      s = idle(); s.pv = 1; s.col = cols[i];
      cyc(s);
    end
  endtask

  task automatic swap();
    in_t s;
    s = idle(); s.ls = 1;
    cyc(s);
  endtask

  task automatic flush();
    in_t s;
    s = idle(); s.rd = 1;
    for (int i = 0; i < 512; i++) cyc(s);
    swap();
    for (int i = 0; i < 512; i++) cyc(s);
    swap();
  endtask

  task automatic test_reset();
    drive_idle();
    RESET = 0;
    #2 RESET = 1;
    #1;
    nchk++;
    if (PA !== 12'h000) begin
      nerr++; $display("FAIL reset_pa: got %h want 000", PA);
    end
    nchk++;
    if (WR_BANK !== 1'b0) begin
      nerr++; $display("FAIL reset_bank: got %b want 0", WR_BANK);
    end
    @(posedge clk);
    #3 RESET = 0;
    model_reset();
    flush();
    nchk++;
    if (WR_BANK !== 1'b0 || PA !== 12'h000) begin
      nerr++;
      $display("FAIL flush_state: bank %b pa %h want 0 000", WR_BANK, PA);
    end
  endtask

  task automatic test_basic();
    in_t s;
    write_sprite(10, 8'h23, 0, '{5, 0, 7});
    swap();
    nchk++;
    if (WR_BANK !== 1'b1) begin
      nerr++; $display("FAIL basic_bank: got %b want 1", WR_BANK);
    end
    for (int i = 0; i < 512; i++) begin
      s = idle(); s.rd = 1;
      cyc(s);
      if (i == 10 || i == 11 || i == 12) begin
        nchk++;
        if (PA !== (i == 10 ? 12'h235 : i == 12 ? 12'h237 : 12'h000)) begin
          nerr++; $display("FAIL basic_pix%0d: got %h", i, PA);
        end
      end
      nchk++;
      if (PA !== 12'(exp_pa)) begin
        nerr++; $display("FAIL basic_model px%0d: got %h want %h", i, PA, exp_pa);
      end
    end
  endtask

  task automatic test_hflip_wrap();
    in_t s;
    write_sprite(0, 8'h5C, 1, '{1, 2});
    swap();
    for (int i = 0; i < 512; i++) begin
      s = idle(); s.rd = 1;
      cyc(s);
      if (i == 0 || i == 511) begin
        nchk++;
        if (PA !== (i == 0 ? 12'h5C1 : 12'h5C2)) begin
          nerr++; $display("FAIL hflip_wrap px%0d: got %h", i, PA);
        end
      end
      nchk++;
      if (PA !== 12'(exp_pa)) begin
        nerr++; $display("FAIL hflip_model px%0d: got %h want %h", i, PA, exp_pa);
      end
    end
  endtask

  task automatic test_fix();
    in_t s;
    for (int pass = 0; pass < 2; pass++) begin
      write_sprite(4, 8'h10, 0, '{3});
      swap();
      for (int i = 0; i < 512; i++) begin
        s = idle(); s.rd = 1;
        if (i == 4 && pass == 0) begin s.fc = 9; s.fp = 4'hA; end
        if (i == 4 && pass == 1) s.fp = 4'hA;
        cyc(s);
        if (i == 4) begin
          nchk++;
          if (PA !== (pass == 0 ? 12'h0A9 : 12'h103)) begin
            nerr++; $display("FAIL fix_pass%0d: got %h", pass, PA);
          end
        end
        nchk++;
        if (PA !== 12'(exp_pa)) begin
          nerr++; $display("FAIL fix_model px%0d: got %h want %h", i, PA, exp_pa);
        end
      end
    end
  endtask

  task automatic test_clear();
    in_t s;
    write_sprite(100, 8'h77, 0, '{1, 2, 3, 4});
    swap();
    s = idle(); s.rd = 1;
    for (int i = 0; i < 512; i++) cyc(s);
    swap();
    swap();
    for (int i = 0; i < 512; i++) begin
      cyc(s);
      nchk++;
      if (PA !== 12'h000 || PA !== 12'(exp_pa)) begin
        nerr++; $display("FAIL clear px%0d: got %h want 000", i, PA);
      end
    end
  endtask

  task automatic test_chbl();
    in_t s;
    write_sprite(7, 8'h44, 0, '{14});
    swap();
    for (int i = 0; i < 512; i++) begin
      s = idle(); s.rd = 1; s.chbl = (i == 7);
      cyc(s);
      if (i == 7) begin
        nchk++;
        if (PA !== 12'h000) begin
          nerr++; $display("FAIL chbl_blank: got %h want 000", PA);
        end
      end
    end
    swap();
    swap();
    for (int i = 0; i < 512; i++) begin
      s = idle(); s.rd = 1;
      cyc(s);
      nchk++;
      if (PA !== 12'(exp_pa) || (i == 7 && PA !== 12'h000)) begin
        nerr++; $display("FAIL chbl_reuse px%0d: got %h want %h", i, PA, exp_pa);
      end
    end
  endtask

  task automatic test_coincident();
    in_t s;
    s = idle();
    s.ls = 1; s.lx = 1; s.x = 20; s.sp = 8'h31; s.pv = 1; s.col = 6;
    cyc(s);
    nchk++;
    if (WR_BANK !== 1'(wb)) begin
      nerr++; $display("FAIL coinc_bank: got %b want %0d", WR_BANK, wb);
    end
    for (int i = 0; i < 512; i++) begin
      s = idle(); s.rd = 1;
      cyc(s);
      if (i == 20) begin
        nchk++;
        if (PA !== 12'h316) begin
          nerr++; $display("FAIL coinc_pix: got %h want 316", PA);
        end
      end
    end
  endtask

  task automatic test_random();
    in_t s;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        #2 RESET = 1;
        #1;
        nchk++;
        if (PA !== 12'h000 || WR_BANK !== 1'b0) begin
          nerr++;
          $display("FAIL mid_reset_async: pa %h bank %b want 000 0", PA, WR_BANK);
        end
        PIX_VALID = 1; SPR_COLOR = 4'h5; RD_EN = 1;
        LOAD_X = 1; X_IN = 9'd3; LINE_SWAP = 1;
        @(posedge clk);
        #1;
        nchk++;
        if (PA !== 12'h000 || WR_BANK !== 1'b0) begin
          nerr++;
          $display("FAIL mid_reset_hold: pa %h bank %b want 000 0", PA, WR_BANK);
        end
        drive_idle();
        #2 RESET = 0;
        model_reset();
      end
      s = idle();
      s.ls   = ($urandom % 64) == 0;
      s.lx   = ($urandom % 16) == 0;
      s.x    = $urandom % 512;
      s.sp   = $urandom % 256;
      s.hf   = $urandom % 2;
      s.pv   = $urandom % 2;
      s.col  = ($urandom % 4 == 0) ? 0 : $urandom % 16;
      s.rd   = $urandom % 2;
      s.fc   = ($urandom % 4 == 0) ? $urandom % 16 : 0;
      s.fp   = $urandom % 16;
      s.chbl = ($urandom % 16) == 0;
      cyc(s);
      nchk++;
      if (PA !== 12'(exp_pa) || WR_BANK !== 1'(wb)) begin
        nerr++;
        $display("FAIL random c%0d: pa %h bank %b want %h %0d",
                 i, PA, WR_BANK, exp_pa, wb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hflip_wrap();
    test_fix();
    test_clear();
    test_chbl();
    test_coincident();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
